ring_monitor: RTL and testbench

- Downstream checker for the 4-bit one-hot ring counter.
- Samples the counter's `count` output every clock and confirms it is a legal one-hot state that advanced exactly one position.
- Reports the binary position of the hot bit and counts full revolutions.
- Flags one-hot violations and sequence breaks for the system controller; no data path through the block.

---
 rtl/ring_pkg.sv | 12 +
 rtl/onehot_enc.sv | 20 ++
 rtl/ring_monitor.sv | 130 +++++++++++++
 tb/tb_ring_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared state encoding and default widths for ring counter consumers
package ring_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int RING_W = 4;
  localparam int REV_W  = 8;
endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - combinational one-hot to binary encoder with a legality flag
module onehot_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 is_onehot
);
  localparam int PW = $clog2(W);

  // Non-one-hot inputs yield the highest set bit; callers gate on is_onehot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = PW'(i);
    end
  end

  assign is_onehot = (vec != '0) && ((vec & (vec - W'(1))) == '0);
endmodule

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - checks a one-hot ring counter for legality and single-step rotation
module ring_monitor
  import ring_pkg::*;
#(
  parameter int W   = RING_W,
  parameter int CW  = REV_W,
  parameter int DIR = 0
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [W-1:0]         count,
  input  logic                 load,
  output logic [$clog2(W)-1:0] pos,
  output logic                 valid,
  output logic                 onehot_err,
  output logic                 seq_err,
  output logic                 fault,
  output logic                 rev_tick,
  output logic [CW-1:0]        rev_count
);
  localparam int PW = $clog2(W);

  state_t         state;
  logic [W-1:0]   prev;
  logic [W-1:0]   exp_next;
  logic           wrap;
  logic [PW-1:0]  idx;
  logic           oh;

  onehot_enc #(.W(W)) u_enc (
    .vec       (count),
    .idx       (idx),
    .is_onehot (oh)
  );

  // Wrap means the hot bit leaves the end position and re-enters at the start.
  generate
    if (DIR == 0) begin : g_down
      assign exp_next = {prev[0], prev[W-1:1]};
      assign wrap     = prev[0] && count[W-1];
    end else begin : g_up
      assign exp_next = {prev[W-2:0], prev[W-1]};
      assign wrap     = prev[W-1] && count[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      prev       <= '0;
      pos        <= '0;
      valid      <= 1'b0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      fault      <= 1'b0;
      rev_tick   <= 1'b0;
      rev_count  <= '0;
    end else begin
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      rev_tick   <= 1'b0;
      case (state)
        IDLE: begin
          if (oh) begin
            state <= TRACK;
            valid <= 1'b1;
            prev  <= count;
            pos   <= idx;
          end else if (count != '0) begin
            state      <= FAULT;
            fault      <= 1'b1;
            onehot_err <= 1'b1;
          end
        end
        TRACK: begin
          if (load) begin
            state <= RESYNC;
            valid <= 1'b0;
          end else if (count == '0) begin
            state <= IDLE;
            valid <= 1'b0;
          end else if (!oh) begin
            state      <= FAULT;
            valid      <= 1'b0;
            fault      <= 1'b1;
            onehot_err <= 1'b1;
          end else if (count != exp_next) begin
            state   <= FAULT;
            valid   <= 1'b0;
            fault   <= 1'b1;
            seq_err <= 1'b1;
          end else begin
            prev <= count;
            pos  <= idx;
            if (wrap) begin
              rev_tick  <= 1'b1;
              rev_count <= rev_count + CW'(1);
            end
          end
        end
        RESYNC: begin
          if (!load) begin
            if (oh) begin
              state <= TRACK;
              valid <= 1'b1;
              prev  <= count;
              pos   <= idx;
            end else if (count == '0) begin
              state <= IDLE;
            end else begin
              state      <= FAULT;
              fault      <= 1'b1;
              onehot_err <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (load) begin
            state <= RESYNC;
            fault <= 1'b0;
          end else if (count == '0) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ring_monitor.sv
// tb/tb_ring_monitor.sv - directed and randomized checks of ring_monitor against a positional model
module tb_ring_monitor;
  localparam int W  = 4;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic [W-1:0] count = '0;
  logic         load = 1'b0;
  logic [1:0]   pos;
  logic         valid, onehot_err, seq_err, fault, rev_tick;
  logic [CW-1:0] rev_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  ring_monitor #(.W(W), .CW(CW), .DIR(0)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .count      (count),
    .load       (load),
    .pos        (pos),
    .valid      (valid),
    .onehot_err (onehot_err),
    .seq_err    (seq_err),
    .fault      (fault),
    .rev_tick   (rev_tick),
    .rev_count  (rev_count)
  );

  always #5 clk = ~clk;

  // Model: ring position as an integer, modes as independent flags.
  bit m_track, m_resync, m_fault;
  int m_prev_pos, m_pos, m_revs;
  bit m_oh_err, m_seq_err, m_tick;

  function automatic int hot_index(input logic [W-1:0] c);
    for (int i = 0; i < W; i++) if (c[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_track = 0; m_resync = 0; m_fault = 0;
    m_prev_pos = 0; m_pos = 0; m_revs = 0;
    m_oh_err = 0; m_seq_err = 0; m_tick = 0;
  endtask

  task automatic model_step(input logic [W-1:0] c, input logic l);
    int ones, p;
    bit is_oh;
    ones = $countones(c);
    is_oh = (ones == 1);
    p = hot_index(c);
    m_oh_err = 0; m_seq_err = 0; m_tick = 0;
    if (!clr_n) begin
      model_reset();
    end else if (m_fault) begin
      if (l) begin m_fault = 0; m_resync = 1; end
      else if (c == 0) m_fault = 0;
    end else if (m_resync) begin
      if (!l) begin
        m_resync = 0;
        if (is_oh) begin m_track = 1; m_prev_pos = p; m_pos = p; end
        else if (c != 0) begin m_fault = 1; m_oh_err = 1; end
      end
    end else if (m_track) begin
      if (l) begin m_track = 0; m_resync = 1; end
      else if (c == 0) m_track = 0;
      else if (!is_oh) begin m_track = 0; m_fault = 1; m_oh_err = 1; end
      else if (p != (m_prev_pos + W - 1) % W) begin m_track = 0; m_fault = 1; m_seq_err = 1; end
      else begin
        if (m_prev_pos == 0) begin m_tick = 1; m_revs = (m_revs + 1) % (1 << CW); end
        m_prev_pos = p; m_pos = p;
      end
    end else begin
      if (is_oh) begin m_track = 1; m_prev_pos = p; m_pos = p; end
      else if (c != 0) begin m_fault = 1; m_oh_err = 1; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pos",        32'(pos),        32'(m_pos));
      chk("valid",      32'(valid),      32'(m_track));
      chk("onehot_err", 32'(onehot_err), 32'(m_oh_err));
      chk("seq_err",    32'(seq_err),    32'(m_seq_err));
      chk("fault",      32'(fault),      32'(m_fault));
      chk("rev_tick",   32'(rev_tick),   32'(m_tick));
      chk("rev_count",  32'(rev_count),  32'(m_revs));
    end
  end

  task automatic cyc(input logic [W-1:0] c, input logic l);
    count = c;
    load  = l;
    @(posedge clk);
    model_step(c, l);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {24'd0, pos, valid, onehot_err, seq_err, fault, rev_tick, 1'b0},
        32'd0);
    chk({tag, "_revs"}, 32'(rev_count), 32'd0);
  endtask

  logic [W-1:0] ring;
  int r;

  initial begin
    model_reset();
    cmp_en = 1'b1;

    // Case 1: reset with junk on count, then release idle
    cyc(4'b1010, 1'b0);
    cyc(4'b1010, 1'b0);
    chk_all_zero("reset");
    clr_n = 1'b1;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk_all_zero("idle");

    // Case 2: normal rotation with one wrap
    cyc(4'b1000, 1'b0);
    chk("c2_valid", 32'(valid), 32'd1);
    chk("c2_pos3", 32'(pos), 32'd3);
    cyc(4'b0100, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b0001, 1'b0);
    chk("c2_pos0", 32'(pos), 32'd0);
    cyc(4'b1000, 1'b0);
    chk("c2_tick", 32'(rev_tick), 32'd1);
    cyc(4'b0100, 1'b0);
    chk("c2_revs", 32'(rev_count), 32'd1);
    chk("c2_pos2", 32'(pos), 32'd2);
    chk("c2_tick_gone", 32'(rev_tick), 32'd0);

    // Case 3: non-one-hot sample from TRACK at 0100
    cyc(4'b1010, 1'b0);
    chk("c3_oh_err", 32'(onehot_err), 32'd1);
    chk("c3_fault", 32'(fault), 32'd1);
    repeat (3) begin
      cyc(4'b1010, 1'b0);
      chk("c3_quiet", 32'(onehot_err | seq_err), 32'd0);
    end
    cyc(4'b0000, 1'b0);
    chk("c3_clear", 32'({fault, valid}), 32'd0);

    // Case 4: skip, then hold
    cyc(4'b1000, 1'b0);
    cyc(4'b0010, 1'b0);
    chk("c4_skip", 32'({seq_err, onehot_err, fault}), 32'b101);
    cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b0);
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("c4_hold", 32'({seq_err, fault}), 32'b11);
    cyc(4'b0000, 1'b0);

    // Case 5: load resync, including a wrap-looking resync sample
    cyc(4'b1000, 1'b0);
    cyc(4'b0100, 1'b0);
    cyc(4'b1010, 1'b1);
    cyc(4'b1010, 1'b1);
    chk("c5_load", 32'({valid, onehot_err, seq_err, fault}), 32'd0);
    cyc(4'b0010, 1'b0);
    chk("c5_pos1", 32'({valid, pos}), 32'b101);
    cyc(4'b0001, 1'b0);
    chk("c5_pos0", 32'({valid, pos}), 32'b100);
    cyc(4'b0001, 1'b1);
    cyc(4'b1000, 1'b0);
    chk("c5_no_tick", 32'({rev_tick, valid, pos}), 32'b0111);
    chk("c5_revs", 32'(rev_count), 32'd1);

    // Case 6: four revolutions with CW=2, then async reset mid-run
    clr_n = 1'b0;
    model_reset();
    cyc(4'b0000, 1'b0);
    clr_n = 1'b1;
    cyc(4'b1000, 1'b0);
    for (int rv = 1; rv <= 4; rv++) begin
      cyc(4'b0100, 1'b0);
      cyc(4'b0010, 1'b0);
      cyc(4'b0001, 1'b0);
      cyc(4'b1000, 1'b0);
      chk("c6_tick", 32'(rev_tick), 32'd1);
      chk("c6_revs", 32'(rev_count), 32'(rv % 4));
    end
    cyc(4'b0100, 1'b0);
    clr_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async");
    cyc(4'b0010, 1'b0);
    clr_n = 1'b1;
    cyc(4'b0000, 1'b0);
    chk_all_zero("post_rst");

    // Randomized phase: mostly legal rotation with injected faults, loads, clears
    ring = 4'b1000;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        clr_n = 1'b0;
        model_reset();
        cyc(ring, 1'b0);
        clr_n = 1'b1;
      end else if (r < 70) begin
        cyc(ring, 1'b0);
        ring = {ring[0], ring[W-1:1]};
      end else if (r < 78) begin
        cyc(W'($urandom_range(0, 15)), 1'b0);
      end else if (r < 84) begin
        cyc(4'b0000, 1'b0);
      end else if (r < 92) begin
        cyc(W'($urandom_range(0, 15)), 1'b1);
      end else begin
        ring = W'(1) << $urandom_range(0, W - 1);
        cyc(ring, 1'b0);
      end
    end

    cyc(4'b0000, 1'b0);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
